alu_mc: RTL and testbench

- Parametrised, multi-cycle successor to the 8-bit single-cycle datapath ALU; sits between register file and writeback in the CPU core.
- Single-cycle ops complete in one clock; variable shifts and multiply iterate under a Start/Done handshake.
- Registered result, flags, branch enable and sticky halt.

---
 rtl/alu_mc_pkg.sv | 41 ++++
 rtl/alu_mc_if.sv | 34 +++
 rtl/alu_mc_iter.sv | 79 +++++++
 rtl/alu_mc.sv | 199 +++++++++++++++++++
 tb/tb_alu_mc.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_mc_pkg.sv
// alu_mc shared types: opcode classes, FSM states, iterator modes, Funct codes.
// Imported by alu_mc_if, alu_mc_iter and alu_mc.
package alu_mc_pkg;

  typedef enum logic [2:0] {
    OP_ARITH = 3'b000,
    OP_BITS  = 3'b001,
    OP_MOV   = 3'b010,
    OP_MISC  = 3'b011,
    OP_RSVD  = 3'b100,
    OP_BEQ   = 3'b101,
    OP_BNE   = 3'b110,
    OP_HALT  = 3'b111
  } aluop_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_MUL,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    M_SHL,
    M_SHR,
    M_MUL
  } mode_e;

  localparam logic [1:0] F_ADD = 2'b00;
  localparam logic [1:0] F_SUB = 2'b01;
  localparam logic [1:0] F_NOT = 2'b10;
  localparam logic [1:0] F_LSB = 2'b11;

  localparam logic [1:0] F_MSB = 2'b00;
  localparam logic [1:0] F_SLT = 2'b01;
  localparam logic [1:0] F_SHL = 2'b10;
  localparam logic [1:0] F_SHR = 2'b11;

  localparam logic [1:0] F_MUL = 2'b00;

endpackage

// File: rtl/alu_mc_if.sv
// alu_mc bus: Start/Aluop/Funct/DatA/DatB/Immed in,
// Rslt/Busy/Done/Jen/Zf/Cf/Halt out. master = requester, slave = ALU.
interface alu_mc_if #(
  parameter int W     = 8,
  parameter int IMM_W = 4
);
  logic             Start;
  logic [2:0]       Aluop;
  logic [1:0]       Funct;
  logic [W-1:0]     DatA;
  logic [W-1:0]     DatB;
  logic [IMM_W-1:0] Immed;
  logic [W-1:0]     Rslt;
  logic             Busy;
  logic             Done;
  logic             Jen;
  logic             Zf;
  logic             Cf;
  logic             Halt;

  modport master (
    output Start, Aluop, Funct,
    output DatA, DatB, Immed,
    input  Rslt, Busy, Done,
    input  Jen, Zf, Cf, Halt
  );

  modport slave (
    input  Start, Aluop, Funct,
    input  DatA, DatB, Immed,
    output Rslt, Busy, Done,
    output Jen, Zf, Cf, Halt
  );
endinterface

// File: rtl/alu_mc_iter.sv
// Iterative shift / shift-add multiply datapath with step counter.
// Ports: i_load/i_mode/i_a/i_b/i_cnt in, o_nxt (next value), o_last out.
// ALU_MC_MUL_EN compiles the multiplier accumulator and B operand.
module alu_mc_iter
  import alu_mc_pkg::*;
#(
  parameter int W  = 8,
  parameter int CW = $clog2(W) + 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_load,
  input  logic          i_step,
  input  mode_e         i_mode,
  input  logic [W-1:0]  i_a,
`ifdef ALU_MC_MUL_EN
  input  logic [W-1:0]  i_b,
`endif
  input  logic [CW-1:0] i_cnt,
  output logic [W-1:0]  o_nxt,
  output logic          o_last
);

  logic [W-1:0]  r_a;
  logic [CW-1:0] r_cnt;
  mode_e         r_mode;
  logic [W-1:0]  w_a_nxt;

  always_comb begin
    w_a_nxt = r_a;
    case (r_mode)
      M_SHR:   w_a_nxt = r_a >> 1;
      default: w_a_nxt = r_a << 1;
    endcase
  end

  assign o_last = (r_cnt == CW'(1));

`ifdef ALU_MC_MUL_EN
  logic [W-1:0] r_b;
  logic [W-1:0] r_acc;
  logic [W-1:0] w_acc_nxt;

  assign w_acc_nxt = r_acc + (r_b[0] ? r_a : '0);
  assign o_nxt = (r_mode == M_MUL) ? w_acc_nxt
                                   : w_a_nxt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_b   <= '0;
      r_acc <= '0;
    end else if (i_load) begin
      r_b   <= i_b;
      r_acc <= '0;
    end else if (i_step && r_cnt != '0) begin
      r_b   <= r_b >> 1;
      r_acc <= w_acc_nxt;
    end
  end
`else
  assign o_nxt = w_a_nxt;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_a    <= '0;
      r_cnt  <= '0;
      r_mode <= M_SHL;
    end else if (i_load) begin
      r_a    <= i_a;
      r_cnt  <= i_cnt;
      r_mode <= i_mode;
    end else if (i_step && r_cnt != '0) begin
      r_a    <= w_a_nxt;
      r_cnt  <= r_cnt - CW'(1);
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle ops, iterative shifts and multiply.
// Ports: Clk, Reset_n, bus (alu_mc_if.slave). Macro ALU_MC_MUL_EN.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int W     = 8,
  parameter int IMM_W = 4,
  parameter int SH_W  = $clog2(W)
) (
  input logic     Clk,
  input logic     Reset_n,
  alu_mc_if.slave bus
);

  localparam int CW = SH_W + 1;

  state_e       r_state;
  logic [W-1:0] r_rslt;
  logic         r_busy;
  logic         r_done;
  logic         r_jen;
  logic         r_zf;
  logic         r_cf;
  logic         r_halt;

  aluop_e        w_op;
  logic [1:0]    w_fn;
  logic [W-1:0]  w_a;
  logic [W-1:0]  w_b;
  logic [SH_W-1:0] w_amt;
  logic [W:0]    w_sum;
  logic [W-1:0]  w_res;
  logic          w_cf;
  logic          w_jen;
  logic          w_shift;
  logic          w_mul;
  mode_e         w_mode;
  logic          w_acc;
  logic          w_load;
  logic          w_step;
  logic [CW-1:0] w_cnt;
  logic [W-1:0]  w_nxt;
  logic          w_last;

  assign w_op  = aluop_e'(bus.Aluop);
  assign w_fn  = bus.Funct;
  assign w_a   = bus.DatA;
  assign w_b   = bus.DatB;
  assign w_amt = bus.DatB[SH_W-1:0];
  assign w_sum = {1'b0, w_a} + {1'b0, w_b};

  always_comb begin
    w_res   = '0;
    w_cf    = r_cf;
    w_jen   = 1'b0;
    w_shift = 1'b0;
    w_mul   = 1'b0;
    w_mode  = M_SHL;
    unique case (w_op)
      OP_ARITH: begin
        case (w_fn)
          F_ADD: begin
            w_res = w_sum[W-1:0];
            w_cf  = w_sum[W];
          end
          F_SUB: begin
            w_res = w_a - w_b;
            w_cf  = (w_a < w_b);
          end
          F_NOT:   w_res = ~w_a;
          default: w_res = {w_a[0], {(W-1){1'b0}}};
        endcase
      end
      OP_BITS: begin
        case (w_fn)
          F_MSB: w_res = W'(w_a[W-1]);
          F_SLT: w_res = W'(w_a < w_b);
          F_SHL: begin
            w_res   = w_a << w_amt;
            w_shift = (w_amt != '0);
            w_mode  = M_SHL;
          end
          default: begin
            w_res   = w_a >> w_amt;
            w_shift = (w_amt != '0);
            w_mode  = M_SHR;
          end
        endcase
      end
      OP_MOV: w_res = W'(bus.Immed);
      OP_MISC: begin
        if (w_fn == F_MUL) begin
`ifdef ALU_MC_MUL_EN
          w_mul  = 1'b1;
          w_mode = M_MUL;
`endif
          w_res  = '0;
        end else begin
          w_res = w_b;
        end
      end
      OP_RSVD: w_res = '0;
      OP_BEQ: begin
        w_res = W'(w_a == w_b);
        w_jen = (w_a == w_b);
      end
      OP_BNE: begin
        w_res = W'(w_a != w_b);
        w_jen = (w_a != w_b);
      end
      OP_HALT: w_res = r_rslt;
    endcase
  end

  assign w_acc  = bus.Start && !r_halt &&
                  (r_state == S_IDLE);
  assign w_load = w_acc && (w_shift || w_mul);
  assign w_step = (r_state == S_SHIFT) ||
                  (r_state == S_MUL);
  assign w_cnt  = w_mul ? CW'(W) : {1'b0, w_amt};

  alu_mc_iter #(.W(W), .CW(CW)) u_iter (
    .i_clk   (Clk),
    .i_rst_n (Reset_n),
    .i_load  (w_load),
    .i_step  (w_step),
    .i_mode  (w_mode),
    .i_a     (w_a),
`ifdef ALU_MC_MUL_EN
    .i_b     (w_b),
`endif
    .i_cnt   (w_cnt),
    .o_nxt   (w_nxt),
    .o_last  (w_last)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= S_IDLE;
      r_rslt  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_jen   <= 1'b0;
      r_zf    <= 1'b0;
      r_cf    <= 1'b0;
      r_halt  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_acc) begin
            if (w_shift) begin
              r_state <= S_SHIFT;
              r_busy  <= 1'b1;
`ifdef ALU_MC_MUL_EN
            end else if (w_mul) begin
              r_state <= S_MUL;
              r_busy  <= 1'b1;
`endif
            end else begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_jen   <= w_jen;
              r_cf    <= w_cf;
              if (w_op == OP_HALT) begin
                r_halt <= 1'b1;
              end else begin
                r_rslt <= w_res;
                r_zf   <= (w_res == '0);
              end
            end
          end
        end
        S_SHIFT, S_MUL: begin
          if (w_last) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_rslt  <= w_nxt;
            r_zf    <= (w_nxt == '0);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_jen   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Rslt = r_rslt;
  assign bus.Busy = r_busy;
  assign bus.Done = r_done;
  assign bus.Jen  = r_jen;
  assign bus.Zf   = r_zf;
  assign bus.Cf   = r_cf;
  assign bus.Halt = r_halt;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc (W=8): directed and random ops
// against an arithmetic reference model. Honours ALU_MC_MUL_EN.
module tb_alu_mc;
  import alu_mc_pkg::*;

  localparam int W = 8;
  localparam int unsigned MASK = (1 << W) - 1;
`ifdef ALU_MC_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic Clk = 1'b0;
  logic Reset_n;

  alu_mc_if #(.W(W), .IMM_W(4)) bus ();

  alu_mc #(.W(W), .IMM_W(4)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  always #5 Clk = ~Clk;

  int n_tests = 0;
  int n_fail  = 0;

  int unsigned m_rslt = 0;
  bit m_zf = 0;
  bit m_cf = 0;
  bit m_halt = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic predict(input int unsigned op,
                         input int unsigned fn,
                         input int unsigned a,
                         input int unsigned b,
                         input int unsigned imm,
                         output int unsigned r,
                         output bit cfu,
                         output bit cf,
                         output bit jen,
                         output int lat,
                         output bit hlt);
    int unsigned amt;
    int unsigned s;
    amt = b % W;
    r = 0; cfu = 0; cf = 0; jen = 0;
    lat = 1; hlt = 0;
    case (op)
      0: case (fn)
        0: begin
          s = a + b;
          r = s & MASK;
          cfu = 1; cf = (s > MASK);
        end
        1: begin
          r = (a - b) & MASK;
          cfu = 1; cf = (a < b);
        end
        2: r = ~a & MASK;
        default: r = (a & 1) << (W - 1);
      endcase
      1: case (fn)
        0: r = a >> (W - 1);
        1: r = (a < b) ? 1 : 0;
        2: begin
          r = (a << amt) & MASK;
          lat = (amt == 0) ? 1 : amt + 1;
        end
        default: begin
          r = a >> amt;
          lat = (amt == 0) ? 1 : amt + 1;
        end
      endcase
      2: r = imm;
      3: if (fn == 0) begin
        if (MUL_EN) begin
          r = (a * b) & MASK;
          lat = W + 1;
        end else r = 0;
      end else r = b;
      4: r = 0;
      5: begin r = (a == b) ? 1 : 0; jen = (a == b); end
      6: begin r = (a != b) ? 1 : 0; jen = (a != b); end
      default: begin hlt = 1; r = m_rslt; end
    endcase
  endtask

  task automatic run_op(input int unsigned op,
                        input int unsigned fn,
                        input int unsigned a,
                        input int unsigned b,
                        input int unsigned imm,
                        input bit spam);
    int unsigned r;
    bit cfu, cf, jen, hlt;
    int lat, n;
    predict(op, fn, a, b, imm, r, cfu, cf, jen, lat, hlt);
    @(negedge Clk);
    chk("idle_busy", bus.Busy, 0);
    chk("idle_done", bus.Done, 0);
    bus.Start = 1'b1;
    bus.Aluop = 3'(op);
    bus.Funct = 2'(fn);
    bus.DatA  = 8'(a);
    bus.DatB  = 8'(b);
    bus.Immed = 4'(imm);
    @(negedge Clk);
    bus.Start = 1'b0;
    bus.DatA  = 8'($urandom);
    bus.DatB  = 8'($urandom);
    bus.Aluop = 3'($urandom);
    if (m_halt) begin
      for (int i = 0; i < W + 4; i++) begin
        chk("halt_nodone", bus.Done, 0);
        chk("halt_hold", bus.Rslt, m_rslt);
        @(negedge Clk);
      end
      chk("halt_sticky", bus.Halt, 1);
      return;
    end
    n = 1;
    while (bus.Done !== 1'b1 && n < 100) begin
      chk("busy", bus.Busy, 1);
      if (spam) begin
        bus.Start = 1'b1;
        bus.Aluop = 3'($urandom_range(0, 6));
        bus.Funct = 2'($urandom);
      end
      @(negedge Clk);
      n++;
    end
    bus.Start = 1'b0;
    chk("latency", n, lat);
    chk("done_notbusy", bus.Busy, 0);
    if (!hlt) begin
      m_rslt = r;
      m_zf = (r == 0);
    end
    if (cfu) m_cf = cf;
    if (hlt) m_halt = 1;
    chk("rslt", bus.Rslt, m_rslt);
    chk("zf", bus.Zf, m_zf);
    chk("cf", bus.Cf, m_cf);
    chk("jen", bus.Jen, jen);
    chk("halt", bus.Halt, m_halt);
    @(negedge Clk);
    chk("done_pulse", bus.Done, 0);
    chk("jen_after", bus.Jen, 0);
    chk("rslt_hold", bus.Rslt, m_rslt);
  endtask

  task automatic chk_reset_outs();
    chk("rst_rslt", bus.Rslt, 0);
    chk("rst_busy", bus.Busy, 0);
    chk("rst_done", bus.Done, 0);
    chk("rst_jen", bus.Jen, 0);
    chk("rst_zf", bus.Zf, 0);
    chk("rst_cf", bus.Cf, 0);
    chk("rst_halt", bus.Halt, 0);
    m_rslt = 0; m_zf = 0; m_cf = 0; m_halt = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset_n = 1'b0;
    bus.Start = 1'b0;
    bus.Aluop = '0;
    bus.Funct = '0;
    bus.DatA  = '0;
    bus.DatB  = '0;
    bus.Immed = '0;
    #12;
    chk_reset_outs();
    @(negedge Clk);
    Reset_n = 1'b1;

    run_op(0, 0, 'hF0, 'h20, 0, 0);
    run_op(1, 2, 'h01, 5, 0, 1);
    run_op(1, 2, 'hA7, 0, 0, 0);
    run_op(1, 3, 'h80, 7, 0, 1);
    run_op(3, 0, 13, 11, 0, 1);
    run_op(2, 0, 0, 0, 'hC, 0);
    run_op(5, 0, 'h55, 'h55, 0, 0);
    run_op(6, 0, 'h55, 'h55, 0, 0);

    // abort a long operation with reset at cycle 4
    @(negedge Clk);
    bus.Start = 1'b1;
    bus.Aluop = MUL_EN ? 3'd3 : 3'd1;
    bus.Funct = MUL_EN ? 2'd0 : 2'd2;
    bus.DatA  = 8'd13;
    bus.DatB  = MUL_EN ? 8'd11 : 8'd7;
    @(negedge Clk);
    bus.Start = 1'b0;
    repeat (2) @(negedge Clk);
    chk("pre_abort_busy", bus.Busy, 1);
    #2;
    Reset_n = 1'b0;
    #1;
    chk_reset_outs();
    @(negedge Clk);
    Reset_n = 1'b1;
    for (int i = 0; i < W + 4; i++) begin
      chk("abort_nodone", bus.Done, 0);
      @(negedge Clk);
    end
    run_op(0, 1, 3, 5, 0, 0);

    for (int i = 0; i < 200; i++) begin
      run_op($urandom_range(0, 6), $urandom_range(0, 3),
             $urandom_range(0, 255), $urandom_range(0, 255),
             $urandom_range(0, 15), 1'($urandom));
    end

    run_op(7, 0, 0, 0, 0, 0);
    run_op(0, 0, 1, 2, 0, 0);
    @(negedge Clk);
    Reset_n = 1'b0;
    #1;
    chk_reset_outs();
    @(negedge Clk);
    Reset_n = 1'b1;
    run_op(0, 0, 1, 2, 0, 0);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
